// File: rtl/alu_exec_if.sv
// Handshake and result bus between the sequencer and the multi-cycle ALU.
interface alu_exec_if #(
    parameter int word_size = 16
);
    logic                 start;
    logic [3:0]           opcode;
    logic [word_size-1:0] operand_a;
    logic [word_size-1:0] operand_b;
    logic                 busy;
    logic [word_size-1:0] acc_result;
    logic                 acc_enable;
    logic [3:0]           flags;
    logic                 div_zero;
    logic                 illegal_op;

    modport master (
        output start, opcode, operand_a, operand_b,
        input  busy, acc_result, acc_enable, flags, div_zero, illegal_op
    );

    modport slave (
        input  start, opcode, operand_a, operand_b,
        output busy, acc_result, acc_enable, flags, div_zero, illegal_op
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU sitting between the register file and accumulator R0.
// Single-cycle ops go IDLE->EXEC->WRITE; MUL/DIV/MOD iterate one bit per
// clock in ITER using a shared hi/lo work register pair.
module alu_exec_unit #(
    parameter int word_size = 16
) (
    input logic       clk,
    input logic       rst_n,
    alu_exec_if.slave bus
);
    localparam int cnt_w = $clog2(word_size) + 1;
    localparam logic [cnt_w-1:0]     last_step = cnt_w'(word_size);
    localparam logic [cnt_w-1:0]     cnt_one   = cnt_w'(1);
    localparam logic [word_size-1:0] one       = word_size'(1);
    localparam logic [word_size-1:0] max_pos   = {1'b0, {(word_size-1){1'b1}}};
    localparam logic [word_size-1:0] min_neg   = {1'b1, {(word_size-1){1'b0}}};
    localparam int msb = word_size - 1;

    localparam logic [3:0] op_add  = 4'h0;
    localparam logic [3:0] op_sub  = 4'h1;
    localparam logic [3:0] op_and  = 4'h2;
    localparam logic [3:0] op_or   = 4'h3;
    localparam logic [3:0] op_xor  = 4'h4;
    localparam logic [3:0] op_not  = 4'h5;
    localparam logic [3:0] op_shl  = 4'h6;
    localparam logic [3:0] op_shr  = 4'h7;
    localparam logic [3:0] op_inc  = 4'h8;
    localparam logic [3:0] op_dec  = 4'h9;
    localparam logic [3:0] op_mul  = 4'hA;
    localparam logic [3:0] op_div  = 4'hB;
    localparam logic [3:0] op_mod  = 4'hC;
    localparam logic [3:0] op_pass = 4'hD;

    typedef enum logic [2:0] {IDLE, EXEC, ITER, WRITE, FAULT} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic [word_size-1:0] a_q, b_q, hi_q, lo_q, acc_q;
    logic [3:0]           flags_q;
    logic                 dz_q;
    logic [cnt_w-1:0]     cnt_q;

    logic [word_size:0]   sum_wide;
    logic [word_size-1:0] sc_result;
    logic                 sc_c, sc_v;
    logic [word_size:0]   mul_sum, div_shift;
    logic [word_size-1:0] div_diff, div_rem, it_result;
    logic                 div_fits, it_c;

    assign bus.busy       = (state_q != IDLE);
    assign bus.acc_enable = (state_q == WRITE);
    assign bus.illegal_op = (state_q == FAULT);
    assign bus.acc_result = acc_q;
    assign bus.flags      = flags_q;
    assign bus.div_zero   = dz_q;

    // Single-cycle result and carry/overflow from the latched operands.
    always_comb begin
        sum_wide  = '0;
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (op_q)
            op_add: begin
                sum_wide  = {1'b0, a_q} + {1'b0, b_q};
                sc_result = sum_wide[msb:0];
                sc_c      = sum_wide[word_size];
                sc_v      = (a_q[msb] == b_q[msb]) && (sc_result[msb] != a_q[msb]);
            end
            op_sub: begin
                sc_result = a_q - b_q;
                sc_c      = (a_q < b_q);
                sc_v      = (a_q[msb] != b_q[msb]) && (sc_result[msb] != a_q[msb]);
            end
            op_and:  sc_result = a_q & b_q;
            op_or:   sc_result = a_q | b_q;
            op_xor:  sc_result = a_q ^ b_q;
            op_not:  sc_result = ~a_q;
            op_shl: begin
                sc_result = {a_q[msb-1:0], 1'b0};
                sc_c      = a_q[msb];
            end
            op_shr: begin
                sc_result = {1'b0, a_q[msb:1]};
                sc_c      = a_q[0];
            end
            op_inc: begin
                sc_result = a_q + one;
                sc_c      = (a_q == '1);
                sc_v      = (a_q == max_pos);
            end
            op_dec: begin
                sc_result = a_q - one;
                sc_c      = (a_q == '0);
                sc_v      = (a_q == min_neg);
            end
            op_mul:  sc_result = '0;
            op_div:  sc_result = '1;
            op_mod:  sc_result = a_q;
            op_pass: sc_result = b_q;
            default: sc_result = '0;
        endcase
    end

    // One shift-add multiply step or restoring divide step, plus the final pick.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_shift = {hi_q, lo_q[msb]};
        div_fits  = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[msb:0] - b_q;
        div_rem   = div_fits ? div_diff : div_shift[msb:0];
        it_result = (op_q == op_mod) ? hi_q : lo_q;
        it_c      = (op_q == op_mul) && (hi_q != '0);
    end

    // State register; an async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state selection; long ops with a zero divisor/multiplier take the short path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.opcode inside {4'hE, 4'hF})
                        state_d = FAULT;
                    else if ((bus.opcode inside {op_mul, op_div, op_mod}) && (bus.operand_b != '0))
                        state_d = ITER;
                    else
                        state_d = EXEC;
                end
            end
            EXEC:    state_d = WRITE;
            ITER:    if (cnt_q == last_step) state_d = WRITE;
            WRITE:   state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.opcode;
                        a_q   <= bus.operand_a;
                        b_q   <= bus.operand_b;
                        hi_q  <= '0;
                        lo_q  <= (bus.opcode == op_mul) ? bus.operand_b : bus.operand_a;
                        cnt_q <= '0;
                        dz_q  <= 1'b0;
                    end
                end
                EXEC: begin
                    acc_q   <= sc_result;
                    flags_q <= {(sc_result == '0), sc_result[msb], sc_c, sc_v};
                    if (op_q == op_div || op_q == op_mod) dz_q <= 1'b1;
                end
                ITER: begin
                    if (cnt_q != last_step) begin
                        cnt_q <= cnt_q + cnt_one;
                        if (op_q == op_mul) begin
                            hi_q <= mul_sum[word_size:1];
                            lo_q <= {mul_sum[0], lo_q[msb:1]};
                        end else begin
                            hi_q <= div_rem;
                            lo_q <= {lo_q[msb-1:0], div_fits};
                        end
                    end else begin
                        acc_q   <= it_result;
                        flags_q <= {(it_result == '0), it_result[msb], it_c, 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus a
// randomized phase, all outputs compared every cycle against a model.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst_n;

    alu_exec_if #(.word_size(16)) bus ();

    alu_exec_unit #(.word_size(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: edge index, accepted-start edge, write edge, end-of-busy edge.
    int          m_edge  = 0;
    int          m_k     = -100;
    int          m_wr    = -100;
    int          m_end   = -100;
    logic        m_fault = 1'b0;
    logic [15:0] m_acc   = '0;
    logic [3:0]  m_fl    = '0;
    logic        m_dz    = 1'b0;
    logic [15:0] p_res;
    logic [3:0]  p_fl;
    logic        p_dz;
    int          p_lat;
    logic        p_fault;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural result of one operation from plain arithmetic.
    function automatic void model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] res, output logic [3:0] fl, output logic dz,
                                     output int lat, output logic fault);
        int ua, ub, sa, sb;
        longint p;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; dz = 1'b0; lat = 1; fault = 1'b0; res = '0;
        case (op)
            4'h0: begin res = a + b; c = (ua + ub) > 65535; v = (sa + sb) > 32767 || (sa + sb) < -32768; end
            4'h1: begin res = a - b; c = ua < ub; v = (sa - sb) > 32767 || (sa - sb) < -32768; end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = ~a;
            4'h6: begin res = a << 1; c = a[15]; end
            4'h7: begin res = a >> 1; c = a[0]; end
            4'h8: begin res = a + 16'd1; c = (ua == 65535); v = (sa + 1) > 32767; end
            4'h9: begin res = a - 16'd1; c = (ua == 0); v = (sa - 1) < -32768; end
            4'hA: begin
                p = longint'(ua) * longint'(ub);
                res = p[15:0]; c = p > 65535; lat = (ub == 0) ? 1 : 17;
            end
            4'hB: begin
                if (ub == 0) begin res = 16'hFFFF; dz = 1'b1; end
                else begin res = 16'(ua / ub); lat = 17; end
            end
            4'hC: begin
                if (ub == 0) begin res = a; dz = 1'b1; end
                else begin res = 16'(ua % ub); lat = 17; end
            end
            4'hD: res = b;
            default: begin fault = 1'b1; lat = 0; end
        endcase
        fl = {(res == 16'h0), res[15], c, v};
    endfunction

    // Compare every DUT output each cycle, then predict the next edge's start.
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            m_edge++;
            if (!rst_n) begin
                m_acc = '0; m_fl = '0; m_dz = 1'b0;
                m_k = -100; m_wr = -100; m_end = -100; m_fault = 1'b0;
            end else begin
                if (m_edge == m_k) m_dz = 1'b0;
                if (m_edge == m_wr) begin m_acc = p_res; m_fl = p_fl; m_dz = p_dz; end
            end
            checkOutput("busy",       bus.busy,       (m_edge >= m_k) && (m_edge < m_end));
            checkOutput("acc_enable", bus.acc_enable, m_edge == m_wr);
            checkOutput("illegal_op", bus.illegal_op, m_fault && (m_edge == m_k));
            checkOutput("acc_result", bus.acc_result, m_acc);
            checkOutput("flags",      bus.flags,      m_fl);
            checkOutput("div_zero",   bus.div_zero,   m_dz);
            if (rst_n && bus.start && (m_edge + 1) > m_end) begin
                m_k = m_edge + 1;
                model_op(bus.opcode, bus.operand_a, bus.operand_b, p_res, p_fl, p_dz, p_lat, p_fault);
                m_fault = p_fault;
                if (p_fault) begin m_wr = -100; m_end = m_k + 1; end
                else begin m_wr = m_k + p_lat; m_end = m_wr + 1; end
            end
        end
    end

    // Issue one operation, scramble inputs after the start edge, wait for completion.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input bit noisy, output logic [15:0] res, output logic [3:0] fl,
                                 output logic dz, output int lat, output logic got_en);
        int  i;
        bit  found;
        res = '0; fl = '0; dz = 1'b0; lat = -1; got_en = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.opcode = op; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.opcode = 4'h0; bus.operand_a = ~a; bus.operand_b = b ^ 16'h5A5A;
        found = 1'b0; i = 0;
        while (!found && i < 40) begin
            @(negedge clk);
            if (bus.acc_enable || bus.illegal_op) begin
                found = 1'b1; lat = i; got_en = bus.acc_enable;
                res = bus.acc_result; fl = bus.flags; dz = bus.div_zero;
            end else begin
                if (noisy && i == 3) begin
                    @(posedge clk); #1;
                    bus.start = 1'b1; bus.opcode = 4'h0; bus.operand_a = 16'h1234;
                end else if (noisy && i == 4) begin
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
                i++;
            end
        end
        checkOutput("done_in_time", found, 1'b1);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] r_res;
    logic [3:0]  r_fl;
    logic        r_dz, r_en;
    int          r_lat;
    int          en_cnt;

    initial begin : stim_proc
        rst_n = 1'b0;
        bus.start = 1'b0; bus.opcode = '0; bus.operand_a = '0; bus.operand_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy",   bus.busy,       1'b0);
        checkOutput("reset_result", bus.acc_result, 16'h0000);
        checkOutput("reset_flags",  bus.flags,      4'h0);

        applyStimulus(4'h0, 16'h7FFF, 16'h0001, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("add_res", r_res, 16'h8000);
        checkOutput("add_flags", r_fl, 4'h5);
        checkOutput("add_lat", r_lat, 1);
        checkOutput("add_en", r_en, 1'b1);

        applyStimulus(4'h1, 16'h0003, 16'h0005, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("sub_res", r_res, 16'hFFFE);
        checkOutput("sub_flags", r_fl, 4'h6);

        applyStimulus(4'h6, 16'h8001, 16'h0000, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("shl_res", r_res, 16'h0002);
        checkOutput("shl_flags", r_fl, 4'h2);

        applyStimulus(4'hA, 16'h0100, 16'h0100, 1'b1, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("mul_res", r_res, 16'h0000);
        checkOutput("mul_flags", r_fl, 4'hA);
        checkOutput("mul_lat", r_lat, 17);

        applyStimulus(4'hB, 16'h0064, 16'h0007, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("div_res", r_res, 16'h000E);
        checkOutput("div_lat", r_lat, 17);

        applyStimulus(4'hC, 16'h0064, 16'h0007, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("mod_res", r_res, 16'h0002);
        checkOutput("mod_flags", r_fl, 4'h0);

        applyStimulus(4'hB, 16'h1234, 16'h0000, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("div0_res", r_res, 16'hFFFF);
        checkOutput("div0_flags", r_fl, 4'h4);
        checkOutput("div0_dz", r_dz, 1'b1);
        checkOutput("div0_lat", r_lat, 1);

        applyStimulus(4'hF, 16'h1111, 16'h2222, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("ill_en", r_en, 1'b0);
        checkOutput("ill_lat", r_lat, 0);
        checkOutput("ill_res", r_res, 16'hFFFF);
        checkOutput("ill_dz", r_dz, 1'b0);

        // Abort a multiply after eight iteration steps.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.opcode = 4'hA; bus.operand_a = 16'h0123; bus.operand_b = 16'h0456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy",   bus.busy,       1'b0);
        checkOutput("abort_result", bus.acc_result, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        en_cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.acc_enable) en_cnt++;
        end
        checkOutput("abort_no_write", en_cnt, 0);

        applyStimulus(4'hD, 16'h0000, 16'hBEEF, 1'b0, r_res, r_fl, r_dz, r_lat, r_en);
        checkOutput("pass_res", r_res, 16'hBEEF);
        checkOutput("pass_flags", r_fl, 4'h4);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 399) != 0);
            bus.start     = rst_n && ($urandom_range(0, 2) == 0);
            bus.opcode    = 4'($urandom_range(0, 15));
            bus.operand_a = pick();
            bus.operand_b = ($urandom_range(0, 7) == 0) ? 16'h0000 : pick();
        end
        @(posedge clk); #1;
        rst_n = 1'b1; bus.start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
